// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite single-outstanding master.
package axil_master_pkg;

    // Transaction FSM states; write and read paths share one controller.
    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRead,
        StRdata,
        StRsp
    } state_e;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite master: turns a simple command/response handshake into one AXI
// read or write transaction at a time. The slave response code is passed
// straight back; there is no retry.
module axil_master
    import axil_master_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  busy,

    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,

    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;

    // State and captured-payload registers with synchronous reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Next-state logic: command capture, channel handshakes, response capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                // AW and W retire independently; leave once both are done.
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                if (M_AXI_BVALID) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                    state_d     = StRsp;
                end
            end
            StRead: begin
                if (M_AXI_ARREADY) begin
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (M_AXI_RVALID) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only, never from READY inputs.
    always_comb begin
        cmd_ready     = (state_q == StIdle);
        busy          = (state_q != StIdle);
        rsp_valid     = (state_q == StRsp);
        rsp_write     = rsp_write_q;
        rsp_rdata     = rsp_rdata_q;
        rsp_resp      = rsp_resp_q;
        M_AXI_AWADDR  = addr_q;
        M_AXI_AWVALID = awvalid_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WSTRB   = wstrb_q;
        M_AXI_WVALID  = wvalid_q;
        M_AXI_BREADY  = (state_q == StWresp);
        M_AXI_ARADDR  = addr_q;
        M_AXI_ARVALID = (state_q == StRead);
        M_AXI_RREADY  = (state_q == StRdata);
    end

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: a delay-configurable register slave
// plus a reference memory model of what every response should contain.
module tb_axil_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [31:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axil_master #(.ADDR_W(32), .DATA_W(64)) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .busy          (busy),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Slave configuration
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          rdata_ovr_en = 0;
    logic [63:0] rdata_ovr = '0;

    // Slave state and observations
    logic [63:0] slv_mem [8];
    logic [63:0] ref_mem [8];
    logic [31:0] aw_addr_cap, ar_addr_cap, awaddr_prev, araddr_prev;
    logic [63:0] w_data_cap, wdata_prev;
    logic [7:0]  w_strb_cap;
    bit          aw_got, w_got, ar_got;
    bit          aw_fire, w_fire, ar_fire, b_fire, r_fire;
    bit          awv_prev, wv_prev, arv_prev;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_hs = 0, w_hs = 0, awv_cycles = 0, wv_cycles = 0;
    int          stab_err = 0, bready_early = 0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Register slave: decides readies/valids at negedge, retires handshakes after posedge.
    initial begin
        for (int i = 0; i < 8; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        awv_prev = 0; wv_prev = 0; arv_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0;
                awv_prev = 0; wv_prev = 0; arv_prev = 0;
                continue;
            end
            // Protocol monitor: VALID held with stable payload until its handshake.
            if (awvalid) awv_cycles++;
            if (wvalid) wv_cycles++;
            if (awv_prev && awvalid && awaddr !== awaddr_prev) stab_err++;
            if (wv_prev && wvalid && wdata !== wdata_prev) stab_err++;
            if (arv_prev && arvalid && araddr !== araddr_prev) stab_err++;
            if (awv_prev && !awvalid && !aw_fire) stab_err++;
            if (wv_prev && !wvalid && !w_fire) stab_err++;
            if (arv_prev && !arvalid && !ar_fire) stab_err++;
            if (bready && !(aw_got && w_got)) bready_early++;
            awv_prev = awvalid; awaddr_prev = awaddr;
            wv_prev = wvalid; wdata_prev = wdata;
            arv_prev = arvalid; araddr_prev = araddr;

            if (awvalid && !aw_got) begin
                if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
            end
            if (wvalid && !w_got) begin
                if (w_cnt >= w_delay) wready = 1; else w_cnt++;
            end
            if (arvalid && !ar_got) begin
                if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
            end
            if (aw_got && w_got && !bvalid) begin
                if (b_cnt >= b_delay) begin bvalid = 1; bresp = bresp_cfg; end else b_cnt++;
            end
            if (ar_got && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid = 1;
                    rdata = rdata_ovr_en ? rdata_ovr : slv_mem[ar_addr_cap[5:3]];
                    rresp = rresp_cfg;
                end else r_cnt++;
            end
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            ar_fire = arvalid && arready;
            b_fire  = bvalid && bready;
            r_fire  = rvalid && rready;
            if (aw_fire) begin aw_got = 1; aw_addr_cap = awaddr; aw_hs++; end
            if (w_fire) begin w_got = 1; w_data_cap = wdata; w_strb_cap = wstrb; w_hs++; end
            if (ar_fire) begin ar_got = 1; ar_addr_cap = araddr; end
            if (aw_fire || w_fire || ar_fire || b_fire || r_fire) begin
                @(posedge clk); #1;
                if (aw_fire) awready = 0;
                if (w_fire) wready = 0;
                if (ar_fire) arready = 0;
                if (b_fire) begin
                    slv_mem[aw_addr_cap[5:3]] = merge(slv_mem[aw_addr_cap[5:3]], w_data_cap,
                                                      w_strb_cap);
                    bvalid = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end
                if (r_fire) begin
                    rvalid = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
                end
            end
        end
    end

    task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [63:0] d,
                             input logic [7:0] s, output bit ok, output int acc);
        bit seen;
        seen = 0; acc = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin seen = 1; break; end
            @(negedge clk);
        end
        if (seen) begin @(posedge clk); #1; acc = cyc; end
        cmd_valid = 0;
        n_total++;
        if (!seen) $display("FAIL cmd_accept: cmd_ready=0 required 1 within 100 cycles");
        else n_pass++;
        ok = seen;
    endtask

    task automatic wait_rsp(input int hold, output bit ok, output logic w,
                            output logic [63:0] rd, output logic [1:0] rr,
                            output int first, output bit stable);
        bit seen;
        seen = 0; stable = 1; first = 0; w = 0; rd = '0; rr = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1; break; end
        end
        n_total++;
        if (!seen) $display("FAIL rsp_wait: rsp_valid=0 required 1 within 200 cycles");
        else n_pass++;
        ok = seen;
        if (seen) begin
            first = cyc; w = rsp_write; rd = rsp_rdata; rr = rsp_resp;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!(rsp_valid === 1'b1 && rsp_write === w && rsp_rdata === rd &&
                      rsp_resp === rr && cmd_ready === 1'b0)) stable = 0;
            end
            rsp_ready = 1;
            @(posedge clk); #1;
            rsp_ready = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy} !== 7'b0)
            $display("FAIL reset_valids: got %b required 0000000",
                     {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy});
        else n_pass++;
        n_total++;
        if (rsp_rdata !== 64'h0 || rsp_resp !== 2'b00 || rsp_write !== 1'b0)
            $display("FAIL reset_rsp: rdata=%h resp=%b write=%b required zeros",
                     rsp_rdata, rsp_resp, rsp_write);
        else n_pass++;
        @(negedge clk); rst = 0;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_basic();
        bit ok, stable; int acc, first, hs0, ws0; logic w; logic [63:0] rd; logic [1:0] rr;
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
        hs0 = aw_hs; ws0 = w_hs;
        issue_cmd(1'b1, 32'h10, 64'h0000_0000_1234_5678, 8'h0F, ok, acc);
        wait_rsp(0, ok, w, rd, rr, first, stable);
        ref_mem[2] = merge(ref_mem[2], 64'h0000_0000_1234_5678, 8'h0F);
        n_total++;
        if (aw_hs - hs0 != 1 || w_hs - ws0 != 1)
            $display("FAIL wr_basic_hs: aw=%0d w=%0d required 1 1", aw_hs - hs0, w_hs - ws0);
        else n_pass++;
        n_total++;
        if (aw_addr_cap !== 32'h10 || w_data_cap !== 64'h1234_5678 || w_strb_cap !== 8'h0F)
            $display("FAIL wr_basic_payload: addr=%h data=%h strb=%h required 10 12345678 0f",
                     aw_addr_cap, w_data_cap, w_strb_cap);
        else n_pass++;
        n_total++;
        if (w !== 1'b1 || rr !== 2'b00 || rd !== 64'h0)
            $display("FAIL wr_basic_rsp: write=%b resp=%b rdata=%h required 1 00 0", w, rr, rd);
        else n_pass++;
        n_total++;
        if (first - acc != 2)
            $display("FAIL wr_latency: got %0d cycles required 2", first - acc);
        else n_pass++;
    endtask

    task automatic test_write_aw_delay();
        bit ok, stable; int acc, first; logic w; logic [63:0] rd; logic [1:0] rr;
        aw_delay = 3; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
        awv_cycles = 0; wv_cycles = 0; stab_err = 0; bready_early = 0;
        issue_cmd(1'b1, 32'h28, 64'hA5A5_0101_C3C3_7E7E, 8'hFF, ok, acc);
        wait_rsp(0, ok, w, rd, rr, first, stable);
        ref_mem[5] = merge(ref_mem[5], 64'hA5A5_0101_C3C3_7E7E, 8'hFF);
        n_total++;
        if (awv_cycles != 4) $display("FAIL aw_delay_awvalid: got %0d cycles required 4",
                                      awv_cycles);
        else n_pass++;
        n_total++;
        if (wv_cycles != 1) $display("FAIL aw_delay_wvalid: got %0d cycles required 1",
                                     wv_cycles);
        else n_pass++;
        n_total++;
        if (stab_err != 0) $display("FAIL aw_delay_stable: got %0d errors required 0", stab_err);
        else n_pass++;
        n_total++;
        if (bready_early != 0)
            $display("FAIL aw_delay_bready: got %0d early cycles required 0", bready_early);
        else n_pass++;
        n_total++;
        if (aw_addr_cap !== 32'h28 || w !== 1'b1)
            $display("FAIL aw_delay_rsp: addr=%h write=%b required 28 1", aw_addr_cap, w);
        else n_pass++;
        aw_delay = 0;
    endtask

    task automatic test_read_wait();
        bit ok, stable; int acc, first; logic w; logic [63:0] rd; logic [1:0] rr;
        r_delay = 2; rresp_cfg = 2'b00;
        rdata_ovr_en = 1; rdata_ovr = 64'hDEAD_BEEF_DEAD_BEEF;
        issue_cmd(1'b0, 32'h18, 64'h0, 8'h0, ok, acc);
        wait_rsp(0, ok, w, rd, rr, first, stable);
        n_total++;
        if (rd !== 64'hDEAD_BEEF_DEAD_BEEF || w !== 1'b0 || rr !== 2'b00)
            $display("FAIL rd_wait_rsp: rdata=%h write=%b resp=%b required deadbeefdeadbeef 0 00",
                     rd, w, rr);
        else n_pass++;
        n_total++;
        if (ar_addr_cap !== 32'h18) $display("FAIL rd_wait_addr: got %h required 18", ar_addr_cap);
        else n_pass++;
        rdata_ovr_en = 0; r_delay = 0;
    endtask

    task automatic test_read_slverr_hold();
        bit ok, stable; int acc, first; logic w; logic [63:0] rd; logic [1:0] rr;
        rresp_cfg = 2'b10;
        issue_cmd(1'b0, 32'h2C, 64'h0, 8'h0, ok, acc);
        wait_rsp(5, ok, w, rd, rr, first, stable);
        n_total++;
        if (!stable) $display("FAIL slverr_stable: stable=0 required 1");
        else n_pass++;
        n_total++;
        if (rr !== 2'b10 || rd !== ref_mem[5])
            $display("FAIL slverr_rsp: resp=%b rdata=%h required 10 %h", rr, rd, ref_mem[5]);
        else n_pass++;
        n_total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL slverr_after: cmd_ready=%b rsp_valid=%b required 1 0",
                     cmd_ready, rsp_valid);
        else n_pass++;
        rresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit ok, seen; int acc; bit rose;
        b_delay = 1000; seen = 0; rose = 0;
        issue_cmd(1'b1, 32'h08, 64'h1111_2222_3333_4444, 8'hFF, ok, acc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bready) begin seen = 1; break; end
        end
        n_total++;
        if (!seen) $display("FAIL rst_mid_wresp: bready=0 required 1 within 50 cycles");
        else n_pass++;
        @(posedge clk); #2; rst = 1;
        @(posedge clk); #1;
        n_total++;
        if ({awvalid, wvalid, arvalid, rsp_valid, busy, cmd_ready} !== 6'b000001)
            $display("FAIL rst_mid_state: got %b required 000001",
                     {awvalid, wvalid, arvalid, rsp_valid, busy, cmd_ready});
        else n_pass++;
        @(negedge clk); rst = 0;
        b_delay = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) rose = 1;
        end
        n_total++;
        if (rose) $display("FAIL rst_mid_norsp: rsp_valid/busy=1 required 0");
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok, stable; int acc, first; logic w; logic [63:0] rd; logic [1:0] rr;
        logic [63:0] d;
        d = {$urandom, $urandom};
        issue_cmd(1'b1, 32'h00, d, 8'hFF, ok, acc);
        wait_rsp(0, ok, w, rd, rr, first, stable);
        ref_mem[0] = merge(ref_mem[0], d, 8'hFF);
        issue_cmd(1'b0, 32'h00, 64'h0, 8'h0, ok, acc);
        wait_rsp(0, ok, w, rd, rr, first, stable);
        n_total++;
        if (rd !== d || w !== 1'b0)
            $display("FAIL b2b_readback: rdata=%h write=%b required %h 0", rd, w, d);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok, stable; int acc, first; logic w; logic [63:0] rd; logic [1:0] rr;
        logic wr; logic [31:0] a; logic [63:0] d; logic [7:0] s; logic [1:0] er;
        for (int t = 0; t < 24; t++) begin
            wr = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 63));
            d = {$urandom, $urandom};
            s = 8'($urandom);
            er = 2'($urandom);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            bresp_cfg = er; rresp_cfg = er;
            stab_err = 0;
            issue_cmd(wr, a, d, s, ok, acc);
            wait_rsp($urandom_range(0, 2), ok, w, rd, rr, first, stable);
            if (wr) begin
                ref_mem[a[5:3]] = merge(ref_mem[a[5:3]], d, s);
                n_total++;
                if (w !== 1'b1 || rr !== er || rd !== 64'h0 || aw_addr_cap !== a ||
                    w_data_cap !== d || w_strb_cap !== s)
                    $display("FAIL rand_wr[%0d]: write=%b resp=%b rdata=%h addr=%h data=%h strb=%h required 1 %b 0 %h %h %h",
                             t, w, rr, rd, aw_addr_cap, w_data_cap, w_strb_cap, er, a, d, s);
                else n_pass++;
            end else begin
                n_total++;
                if (w !== 1'b0 || rr !== er || rd !== ref_mem[a[5:3]] || ar_addr_cap !== a)
                    $display("FAIL rand_rd[%0d]: write=%b resp=%b rdata=%h addr=%h required 0 %b %h %h",
                             t, w, rr, rd, ar_addr_cap, er, ref_mem[a[5:3]], a);
                else n_pass++;
            end
            n_total++;
            if (stab_err != 0 || !stable)
                $display("FAIL rand_stable[%0d]: errors=%0d rsp_stable=%0d required 0 1",
                         t, stab_err, stable);
            else n_pass++;
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        bresp_cfg = 0; rresp_cfg = 0;
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read_wait();
        test_read_slverr_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 Parameter ADDR_W, 32, AXI address width.
REQ-002 Parameter DATA_W, 64, AXI data width; strobe width is DATA_W/8.
REQ-003 M_AXI_ACLK  in  1  sole clock; all logic samples on its rising edge.
REQ-004 M_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_addr  in  ADDR_W  byte address; cmd_wdata  in  DATA_W  write data; cmd_wstrb  in  DATA_W/8  write strobes.
REQ-008 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-009 rsp_write  out  1; rsp_rdata  out  DATA_W; rsp_resp  out  2  AXI response code.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 M_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite master ports; AWADDR/ARADDR ADDR_W, WDATA/RDATA DATA_W, WSTRB DATA_W/8, BRESP/RRESP 2; no PROT.

Function
REQ-012 States: IDLE, WRITE, WRESP, READ, RDATA, RSP; one transaction outstanding at a time.
REQ-013 cmd_ready is high only in IDLE, combinationally from state.
REQ-014 On cmd accept with cmd_write=1: addr/data/strb captured, go WRITE; AWVALID and WVALID both high in the next cycle.
REQ-015 In WRITE, AW and W handshakes are independent: each VALID drops the cycle after its own READY is seen; leave for WRESP once both are done, in either order or the same cycle.
REQ-016 In WRESP, BREADY is high; on BVALID, capture BRESP, set rsp_write=1, rsp_rdata=0, go RSP.
REQ-017 On cmd accept with cmd_write=0: capture addr, go READ; ARVALID is high until ARREADY is seen, then go RDATA.
REQ-018 In RDATA, RREADY is high; on RVALID, capture RDATA/RRESP, set rsp_write=0, go RSP.
REQ-019 In RSP, rsp_valid is high and the response fields are stable; on rsp_ready go IDLE. cmd_ready rises the cycle after the rsp handshake.
REQ-020 Once asserted, any VALID stays high with stable payload until its READY (AXI rule); VALID never depends combinationally on READY.
REQ-021 AWADDR/ARADDR drive the captured address unmodified; no alignment masking.
REQ-022 Minimum write latency with always-ready slave: cmd accept at N -> AW/W at N+1 -> B seen at N+2 or later -> rsp_valid the cycle after B.
REQ-023 A non-OKAY BRESP/RRESP is passed through unchanged; no retry.

Reset
REQ-024 While M_AXI_ARESET is high: state=IDLE; AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy=0; rsp_rdata=0, rsp_resp=0, rsp_write=0.
REQ-025 Reset mid-transaction abandons it with no response; all VALIDs are low in the first cycle after reset.

Structure
REQ-026 A shared package holds the state enumeration and the AXI response constants OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
REQ-027 The block is a single module with no sub-module; the write and read channels live in one FSM.

Verification
REQ-028 Write addr 0x10, data 0x0000_0000_1234_5678, strb 0x0F, slave ready immediately, BRESP=00 -> one AW and one W handshake, rsp_valid with rsp_write=1 and rsp_resp=00.
REQ-029 Write where AWREADY is delayed 3 cycles and WREADY is immediate -> WVALID drops after 1 cycle, AWVALID is held 4 cycles with stable AWADDR, BREADY rises only after both handshakes.
REQ-030 Read addr 0x18, RDATA=0xDEAD_BEEF_DEAD_BEEF after 2 wait cycles -> rsp_rdata=0xDEAD_BEEF_DEAD_BEEF, rsp_write=0, rsp_resp=00.
REQ-031 Read with RRESP=10 and rsp_ready held low 5 cycles -> rsp_valid and rsp_resp=10 are stable all 5 cycles; cmd_ready stays low until the cycle after rsp_ready.
REQ-032 Reset asserted while waiting in WRESP -> the next cycle shows all VALIDs low, busy=0, cmd_ready=1, and no rsp_valid.
REQ-033 Back-to-back write 0x00 then read 0x00 against a register slave -> the read returns the written 64-bit value.
